fifo: RTL and testbench
=======================

# fifo

Synchronous first-word-fall-through FIFO: 4 entries × 8 bits, one clock domain. It sits between a byte producer and a byte consumer. It buffers up to 4 words and exposes full/empty flags for flow control. Storage is a separate register-file sub-module; the FIFO owns pointers, occupancy count and flags.

## Interface
- `WIDTH`, default 8: data word width.
- `DEPTH`, default 4: number of entries; must be a power of two.
- `AW`, default 2: pointer width, equal to log2(DEPTH).
- `CW`, default 3: occupancy counter width, equal to AW+1.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in WIDTH: write data.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `data_out` out WIDTH: head-of-queue word; combinational, equal to `mem[rd_pointer]`.
- `full` out 1: high when `word_count == DEPTH`.
- `empty` out 1: high when `word_count == 0`.

## Operation
- Internal state, with these exact names so hierarchical probes work:
  - `wr_pointer` [AW-1:0]
  - `rd_pointer` [AW-1:0]
  - `word_count` [CW-1:0]
  - storage instance `mem1` holding array `mem[0:DEPTH-1]`
- Write accepted = `wr_en & ~full`. On acceptance, `mem[wr_pointer] <= data_in` and `wr_pointer` increments.
- Read accepted = `rd_en & ~empty`. On acceptance, `rd_pointer` increments; the word was already presented on `data_out` during that cycle (show-ahead).
- Both accept conditions use the pre-edge `full`/`empty` values.
- Pointers wrap naturally modulo DEPTH (3 → 0).
- `word_count` update:
  - +1 for a write alone.
  - −1 for a read alone.
  - Unchanged when both are accepted or neither is.
- Boundary cases:
  - Write while full (with or without `rd_en`): the write is dropped; the memory and `wr_pointer` are unchanged. A read in the same cycle still proceeds, and the count goes 4 → 3.
  - Read while empty (with or without `wr_en`): the read is ignored. A write in the same cycle still proceeds, and the count goes 0 → 1.
  - When empty, `data_out` shows the stale `mem[rd_pointer]`; consumers must not use it.
- `full` and `empty` decode combinationally from `word_count` and are never both high.

## Timing
- Reset (`rst_n` low, takes effect immediately and asynchronously):
  - `wr_pointer`, `rd_pointer` and `word_count` clear to 0; all `mem` entries clear to 0.
  - Resulting outputs: `empty`=1, `full`=0, `data_out`=0.
  - Reset mid-operation discards all contents.
- Write-to-read latency: a word written at edge N appears on `data_out` after edge N (visible in cycle N+1) if the FIFO was empty. A read may be issued in that cycle.
- Flags update in the same cycle as `word_count`, one edge after the accepted request.
- No other pipeline stages.

## Structure
- Sub-module `fifo_mem`, instanced as `mem1`:
  - Parameters: WIDTH, DEPTH, AW.
  - Array `mem`; synchronous write port (`we`, `waddr`, `wdata`); asynchronous read port (`raddr` → `rdata`); asynchronous active-low reset clearing all entries.
- Shared package `fifo_pkg` holds the defaults: WIDTH=8, DEPTH=4, AW=2, CW=3.

## Test plan
- Reset then idle → `empty`=1, `full`=0, `word_count`=0, `data_out`=8'h00.
- Write 8'hA1, 8'hB2, 8'hC3, 8'hD4 on consecutive cycles → `full`=1 after the 4th edge, and `data_out`=8'hA1. A 5th write of 8'hEE is dropped: `mem` and `wr_pointer` are unchanged.
- From full, read 4 times → `data_out` sequence A1, B2, C3, D4, then `empty`=1 and `rd_pointer`=0 (wrapped).
- With count 2, assert `wr_en` and `rd_en` together for 6 cycles → count stays 2, order preserved, and both pointers wrap.
- When full, assert `wr_en`+`rd_en` → only the read occurs, count becomes 3. When empty, assert `wr_en`+`rd_en` → only the write occurs, count becomes 1, and `data_out` shows the new word.
- Random 100-cycle traffic with requests gated by the flags → the read sequence equals the write sequence. Pulse `rst_n` low mid-stream → immediate `empty`=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the 4 x 8 first-word-fall-through FIFO.
//   FIFO_WIDTH : data word width
//   FIFO_DEPTH : number of entries (power of two)
//   FIFO_AW    : pointer width, log2(FIFO_DEPTH)
//   FIFO_CW    : occupancy counter width, FIFO_AW + 1
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_CW    = FIFO_AW + 1;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem: register-file storage for the FIFO.
//   clk    in  : clock, write on rising edge
//   rst_n  in  : asynchronous active-low reset, clears every entry
//   we     in  : write enable
//   waddr  in  : write address
//   wdata  in  : write data
//   raddr  in  : read address (asynchronous read)
//   rdata  out : mem[raddr], combinational
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO, single clock domain.
//   clk      in  : clock, all state updates on rising edge
//   rst_n    in  : asynchronous active-low reset, discards all contents
//   data_in  in  : write data
//   wr_en    in  : write request
//   rd_en    in  : read request
//   data_out out : head-of-queue word (stale when empty)
//   full     out : word_count == DEPTH
//   empty    out : word_count == 0
//
// Handshake: a write is accepted on a rising edge where wr_en & ~full, a
// read where rd_en & ~empty, both judged on the flags before the edge. An
// unaccepted request has no effect and is not retried; the producer and
// consumer must hold or re-issue it themselves. The head word is already
// on data_out in the cycle the read is requested (show-ahead).
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int CW    = FIFO_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [AW-1:0] wr_pointer, wr_pointer_d;
  logic [AW-1:0] rd_pointer, rd_pointer_d;
  logic [CW-1:0] word_count, word_count_d;
  logic          wr_accept, rd_accept;

  assign full      = (word_count == CW'(DEPTH));
  assign empty     = (word_count == '0);
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  // Pointers are exactly AW bits wide, so the +1 wraps DEPTH-1 -> 0 for free.
  always_comb begin
    wr_pointer_d = wr_pointer;
    rd_pointer_d = rd_pointer;
    word_count_d = word_count;
    if (wr_accept) wr_pointer_d = wr_pointer + AW'(1);
    if (rd_accept) rd_pointer_d = rd_pointer + AW'(1);
    case ({wr_accept, rd_accept})
      2'b10:   word_count_d = word_count + CW'(1);
      2'b01:   word_count_d = word_count - CW'(1);
      default: word_count_d = word_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pointer <= '0;
      rd_pointer <= '0;
      word_count <= '0;
    end else begin
      wr_pointer <= wr_pointer_d;
      rd_pointer <= rd_pointer_d;
      word_count <= word_count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) mem1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept),
    .waddr (wr_pointer),
    .wdata (data_in),
    .raddr (rd_pointer),
    .rdata (data_out)
  );

endmodule : fifo

// File: tb/tb_fifo.sv
// tb_fifo: self-checking bench for fifo. A queue-based reference model is
// updated on each rising edge; a compare process checks every DUT output and
// the probed internal state on each falling edge. Directed phases add literal
// expectations; a randomized phase checks end-to-end ordering.
module tb_fifo;

  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] data_out;
  logic         full, empty;

  always #5 clk = ~clk;

  fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Contents as a plain queue; slot array and slot indices only to predict
  // the stale word shown when empty and the probed pointers.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_mem [D];
  int           m_wp, m_rp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_wp = 0;
      m_rp = 0;
    end else begin
      bit wa, ra;
      wa = wr_en && (exp_q.size() < D);
      ra = rd_en && (exp_q.size() > 0);
      if (ra) begin
        void'(exp_q.pop_front());
        m_rp = (m_rp + 1) % D;
      end
      if (wa) begin
        exp_q.push_back(data_in);
        m_mem[m_wp] = data_in;
        m_wp = (m_wp + 1) % D;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("empty", 32'(empty), 32'(exp_q.size() == 0));
      check("full", 32'(full), 32'(exp_q.size() == D));
      check("word_count", 32'(dut.word_count), 32'(exp_q.size()));
      check("data_out", 32'(data_out), 32'((exp_q.size() > 0) ? exp_q[0] : m_mem[m_rp]));
      check("rd_pointer", 32'(dut.rd_pointer), 32'(m_rp));
      check("wr_pointer", 32'(dut.wr_pointer), 32'(m_wp));
      for (int i = 0; i < D; i++) check("mem", 32'(dut.mem1.mem[i]), 32'(m_mem[i]));
    end
  end

  // ---------------- driver ----------------
  // Called 1 ns after a rising edge; applies inputs, then returns 1 ns after
  // the next rising edge so outputs are settled.
  task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] wr_log[$];
  logic [W-1:0] rd_log[$];
  logic [W-1:0] lit [6];

  initial begin
    // reset, then idle
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(0, 0, 8'h00);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(dut.word_count), 32'd0);
    check("rst_data_out", 32'(data_out), 32'h00);

    // fill, then a dropped write
    cycle(1, 0, 8'hA1);
    check("first_fall_through", 32'(data_out), 32'hA1);
    cycle(1, 0, 8'hB2);
    cycle(1, 0, 8'hC3);
    cycle(1, 0, 8'hD4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_head", 32'(data_out), 32'hA1);
    cycle(1, 0, 8'hEE);
    check("drop_wr_pointer", 32'(dut.wr_pointer), 32'd0);
    check("drop_mem0", 32'(dut.mem1.mem[0]), 32'hA1);
    check("drop_count", 32'(dut.word_count), 32'd4);

    // drain in order
    lit[0] = 8'hA1; lit[1] = 8'hB2; lit[2] = 8'hC3; lit[3] = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 32'(data_out), 32'(lit[i]));
      cycle(0, 1, 8'h00);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rd_wrap", 32'(dut.rd_pointer), 32'd0);

    // steady-state simultaneous read/write at count 2
    cycle(1, 0, 8'h11);
    cycle(1, 0, 8'h22);
    lit[0] = 8'h11; lit[1] = 8'h22; lit[2] = 8'h33;
    lit[3] = 8'h44; lit[4] = 8'h55; lit[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      check("rw_order", 32'(data_out), 32'(lit[i]));
      cycle(1, 1, 8'(8'h33 + 8'(i) * 8'h11));
    end
    check("rw_count", 32'(dut.word_count), 32'd2);
    check("rw_head", 32'(data_out), 32'h77);
    check("rw_wp_wrap", 32'(dut.wr_pointer), 32'd0);
    check("rw_rp", 32'(dut.rd_pointer), 32'd2);

    // full with wr+rd: only the read happens
    cycle(1, 0, 8'h99);
    cycle(1, 0, 8'hAA);
    check("full_again", 32'(full), 32'd1);
    cycle(1, 1, 8'hEE);
    check("full_rw_count", 32'(dut.word_count), 32'd3);
    check("full_rw_head", 32'(data_out), 32'h88);
    check("full_rw_wp", 32'(dut.wr_pointer), 32'd2);

    // empty with wr+rd: only the write happens
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00);
    check("empty_again", 32'(empty), 32'd1);
    cycle(1, 1, 8'h5A);
    check("empty_rw_count", 32'(dut.word_count), 32'd1);
    check("empty_rw_head", 32'(data_out), 32'h5A);
    cycle(0, 1, 8'h00);

    // random flag-gated traffic, order check
    for (int n = 0; n < 100; n++) begin
      logic w, r;
      logic [W-1:0] d;
      w = 1'($urandom_range(0, 1)) & ~full;
      r = 1'($urandom_range(0, 1)) & ~empty;
      d = 8'($urandom_range(0, 255));
      if (r) rd_log.push_back(data_out);
      if (w) wr_log.push_back(d);
      cycle(w, r, d);
    end
    for (int i = 0; i < rd_log.size(); i++) check("rand_order", 32'(rd_log[i]), 32'(wr_log[i]));

    // asynchronous reset mid-stream
    cycle(1, 0, 8'hC7);
    #2 rst_n = 1'b0;
    #1;
    check("async_empty", 32'(empty), 32'd1);
    check("async_full", 32'(full), 32'd0);
    check("async_count", 32'(dut.word_count), 32'd0);
    check("async_data_out", 32'(data_out), 32'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ungated random traffic, exercises write-while-full / read-while-empty
    for (int n = 0; n < 60; n++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    cycle(0, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo
